// File: rtl/iter_shift_ctrl_pkg.sv
// Shared types and default sizes for the iterative shift controller.
package iter_shift_ctrl_pkg;

    localparam int W  = 32;
    localparam int AW = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/iter_shift_ctrl_shift_1b.sv
// One-bit left-shift stage: zero enters bit 0 when i_shift is high, otherwise pass-through.
module shift_1b
    import iter_shift_ctrl_pkg::*;
#(
    parameter int W = iter_shift_ctrl_pkg::W
) (
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    assign o_data = i_shift ? {i_data[W-2:0], 1'b0} : i_data;

endmodule

// File: rtl/iter_shift_ctrl.sv
// Iterative left shifter: one bit per cycle through shift_1b, valid/ready on both sides.
// Optional rotate-left behaviour is enabled by defining ITER_SHIFT_ROTATE_EN.
module iter_shift_ctrl
    import iter_shift_ctrl_pkg::*;
#(
    parameter int W  = iter_shift_ctrl_pkg::W,
    parameter int AW = iter_shift_ctrl_pkg::AW
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [W-1:0]  i_data,
    input  logic [AW-1:0] i_amount,
    input  logic          i_rotate,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [W-1:0]  o_data,
    output logic          o_busy
);

    state_e        state_q;
    logic [W-1:0]  data_q;
    logic [W-1:0]  data_d;
    logic [W-1:0]  stage_out;
    logic [AW-1:0] cnt_q;
    logic          mode_q;
    logic          fill;

    shift_1b #(.W(W)) u_stage (
        .i_shift (state_q == SHIFT),
        .i_data  (data_q),
        .o_data  (stage_out)
    );

`ifdef ITER_SHIFT_ROTATE_EN
    assign fill = mode_q & data_q[W-1];
`else
    // mode is still latched on accept but never reaches the fill in this build
    assign fill = mode_q & 1'b0;
`endif

    assign data_d = {stage_out[W-1:1], stage_out[0] | fill};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        data_q  <= i_data;
                        cnt_q   <= i_amount;
                        mode_q  <= i_rotate;
                        state_q <= (i_amount != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q - AW'(1);
                    if (cnt_q == AW'(1))
                        state_q <= DONE;
                end
                DONE: begin
                    if (i_ready)
                        state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_ready = (state_q == IDLE) & ~sys_rst;
    assign o_valid = (state_q == DONE);
    assign o_busy  = (state_q != IDLE);
    assign o_data  = data_q;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Bench for iter_shift_ctrl: directed table, hold/reset/back-to-back sequences, random ops vs model.
module tb_iter_shift_ctrl;

`ifdef ITER_SHIFT_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_data = '0;
    logic [4:0]  i_amount = '0;
    logic        i_rotate = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_data;
    logic        o_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    iter_shift_ctrl dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_amount (i_amount),
        .i_rotate (i_rotate),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_busy   (o_busy)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Valid and ready must never be seen together outside reset.
    always @(negedge sys_clk)
        if (!sys_rst) chk("vld_rdy_excl", {63'b0, o_valid & o_ready}, 64'd0);

    function automatic logic [31:0] model(input logic [31:0] d, input int n, input bit r);
        logic [63:0] x;
        x = {32'b0, d} << n;
        return x[31:0] | ((ROT && r) ? x[63:32] : 32'h0);
    endfunction

    typedef struct {
        logic [31:0] d;
        logic [4:0]  n;
        logic        r;
        logic [31:0] e_zero;
        logic [31:0] e_rot;
    } vec_t;

    vec_t tbl[6];

    task automatic run_op(input logic [31:0] d, input logic [4:0] n, input logic r,
                          input logic [31:0] e, input bit hold, output int acc);
        int lat;
        int w;
        w = 0;
        while (!o_ready && w < 50) begin
            @(negedge sys_clk);
            w++;
        end
        chk("ready_before", {63'b0, o_ready}, 64'd1);
        i_valid = 1'b1; i_data = d; i_amount = n; i_rotate = r;
        @(posedge sys_clk);
        #1 acc = cyc;
        @(negedge sys_clk);
        i_valid = 1'b0; i_data = $urandom; i_amount = 5'($urandom); i_rotate = 1'($urandom);
        lat = 1;
        while (!o_valid && lat < 40) begin
            chk("busy_shift", {63'b0, o_busy}, 64'd1);
            @(negedge sys_clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(n) + 64'd1);
        chk("data", {32'b0, o_data}, {32'b0, e});
        chk("ready_in_done", {63'b0, o_ready}, 64'd0);
        if (hold) begin
            repeat (5) begin
                i_ready = 1'b0; i_valid = 1'b1; i_data = $urandom; i_amount = 5'd1;
                @(negedge sys_clk);
                chk("hold_valid", {63'b0, o_valid}, 64'd1);
                chk("hold_data", {32'b0, o_data}, {32'b0, e});
                chk("hold_ready", {63'b0, o_ready}, 64'd0);
            end
        end
        i_valid = 1'b0; i_ready = 1'b1;
        @(negedge sys_clk);
        i_ready = 1'b0;
        chk("idle_ready", {63'b0, o_ready}, 64'd1);
        chk("idle_valid", {63'b0, o_valid}, 64'd0);
        chk("idle_busy", {63'b0, o_busy}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int prev;
        int w;
        logic [31:0] d;
        logic [4:0]  n;
        logic        r;

        tbl[0] = '{32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 32'h8000_0000};
        tbl[1] = '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[2] = '{32'h8000_0001, 5'd4,  1'b1, 32'h0000_0010, 32'h0000_0018};
        tbl[3] = '{32'hF000_0000, 5'd4,  1'b1, 32'h0000_0000, 32'h0000_000F};
        tbl[4] = '{32'h1234_5678, 5'd8,  1'b0, 32'h3456_7800, 32'h3456_7800};
        tbl[5] = '{32'h8000_0000, 5'd1,  1'b1, 32'h0000_0000, 32'h0000_0001};

        #1;
        chk("rst_ready", {63'b0, o_ready}, 64'd0);
        chk("rst_valid", {63'b0, o_valid}, 64'd0);
        chk("rst_busy", {63'b0, o_busy}, 64'd0);
        chk("rst_data", {32'b0, o_data}, 64'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        #1 chk("rst_release_ready", {63'b0, o_ready}, 64'd1);
        @(negedge sys_clk);

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].d, tbl[i].n, tbl[i].r, (ROT && tbl[i].r) ? tbl[i].e_rot : tbl[i].e_zero, 1'b0, acc);

        // Consumer stalls in DONE while a second request is offered.
        run_op(32'hA5A5_0F0F, 5'd3, 1'b0, 32'h2D28_7878, 1'b1, acc);

        // Reset in the middle of a 10-bit shift discards the operation.
        i_valid = 1'b1; i_data = 32'h0000_0F00; i_amount = 5'd10; i_rotate = 1'b0;
        @(negedge sys_clk);
        i_valid = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("mid_busy", {63'b0, o_busy}, 64'd1);
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_busy", {63'b0, o_busy}, 64'd0);
        chk("mid_rst_data", {32'b0, o_data}, 64'd0);
        chk("mid_rst_ready", {63'b0, o_ready}, 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        w = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (o_valid) w++;
        end
        chk("mid_rst_no_valid", 64'(w), 64'd0);
        chk("mid_rst_idle", {63'b0, o_ready}, 64'd1);

        // Back-to-back amounts 1,2,3: accept spacing is the previous amount plus two.
        run_op(32'h0000_0003, 5'd1, 1'b0, 32'h0000_0006, 1'b0, prev);
        for (int k = 2; k <= 3; k++) begin
            run_op(32'h0000_0003, 5'(k), 1'b0, model(32'h0000_0003, k, 1'b0), 1'b0, acc);
            chk("b2b_spacing", 64'(acc - prev), 64'(k - 1 + 2));
            prev = acc;
        end

        for (int k = 0; k < 20; k++) begin
            d = $urandom;
            n = 5'($urandom_range(0, 31));
            r = 1'($urandom);
            run_op(d, n, r, model(d, int'(n), r), 1'(($urandom & 3) == 0), acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
